// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared types and helpers for the counter_arbiter slice.
//   state_e : scheduler state (IDLE / RUN / SAT; SAT is only reachable when the
//             design is built with COUNTER_ARB_SAT_EN)
//   resp_t  : ticket response {id, value}, sized for the widest supported
//             configuration (16 requesters, 32-bit counter)
//   id_w()  : width of a requester index for a given requester count
`timescale 1ns/1ps
package counter_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SAT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    SAT  = ST_SAT
  } state_e;

  localparam int MAX_ID_W    = 4;
  localparam int MAX_VALUE_W = 32;

  typedef struct packed {
    logic [MAX_ID_W-1:0]    id;
    logic [MAX_VALUE_W-1:0] value;
  } resp_t;

  // A single requester still needs one index bit so ports never collapse to zero width.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   req [NUM_REQ-1:0] : request vector
//   ptr [ID_W-1:0]    : highest-priority index (must be < NUM_REQ)
//   gnt [NUM_REQ-1:0] : one-hot grant, all zero when no request is set
//   idx [ID_W-1:0]    : encoded index of the granted requester (0 when none)
// The winner is the first set request at or after ptr, searching upward
// modulo NUM_REQ.
`timescale 1ns/1ps
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic            found;
  logic [ID_W-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one WIDTH-bit up-counter between NUM_REQ requesters.
// Each winner receives a ticket equal to the counter value before its increment.
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   enable            : 0 blocks all grants (counter holds; clear still acts)
//   clear             : synchronous clear, overrides any grant in its cycle
//   req_valid/ready   : per-requester handshake, req_ready one-hot combinational
//   resp_valid/id/value : registered ticket strobe one cycle after the grant
//   count             : current counter register
//   sat               : saturated flag, only with COUNTER_ARB_SAT_EN defined
// Build option COUNTER_ARB_SAT_EN: an overflowing grant is still issued, then
// the counter sticks at all-ones and no further grants occur until clear.
// Without it the counter wraps modulo 2^WIDTH.
`timescale 1ns/1ps
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 4,
  parameter  int STEP    = 1,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               resp_valid,
  output logic [ID_W-1:0]    resp_id,
  output logic [WIDTH-1:0]   resp_value,
`ifdef COUNTER_ARB_SAT_EN
  output logic               sat,
`endif
  output logic [WIDTH-1:0]   count
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

`ifdef COUNTER_ARB_SAT_EN
  // Carry-out is kept so the caller can detect overflow.
  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] c);
    return {1'b0, c} + {1'b0, STEP_W};
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] sum);
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction
`else
  function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] c);
    return c + STEP_W;
  endfunction
`endif

  state_e            state;
  state_e            state_nxt;
  logic [WIDTH-1:0]  count_r;
  logic [ID_W-1:0]   rr_ptr;

  logic              active_p0;
  logic [NUM_REQ-1:0] gnt_p0;
  logic [ID_W-1:0]   gnt_idx_p0;
  logic              xfer_p0;
  logic [WIDTH-1:0]  count_nxt_p0;
  logic              ovf_p0;

  logic              resp_vld_p1;
  logic [ID_W-1:0]   resp_id_p1;
  logic [WIDTH-1:0]  resp_value_p1;

  // ---- stage p0: arbitration and next-count computation ----
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt_p0),
    .idx (gnt_idx_p0)
  );

  // IDLE with enable already high behaves as RUN this cycle, so the first
  // grant does not wait for the state register to catch up.
  assign active_p0 = !reset && enable && !clear && (state != SAT);
  assign req_ready = active_p0 ? gnt_p0 : '0;
  assign xfer_p0   = |(req_valid & req_ready);

`ifdef COUNTER_ARB_SAT_EN
  logic [WIDTH:0] sum_p0;
  assign sum_p0       = add_step(count_r);
  assign ovf_p0       = sum_p0[WIDTH];
  assign count_nxt_p0 = saturate(sum_p0);
`else
  assign ovf_p0       = 1'b0;
  assign count_nxt_p0 = add_step(count_r);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: begin
        state_nxt = enable ? RUN : IDLE;
        if (xfer_p0 && ovf_p0) state_nxt = SAT;
      end
      SAT: begin
        if (clear) state_nxt = enable ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count_r       <= '0;
      rr_ptr        <= '0;
      resp_vld_p1   <= 1'b0;
      resp_id_p1    <= '0;
      resp_value_p1 <= '0;
    end else begin
      state       <= state_nxt;
      resp_vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        resp_id_p1    <= gnt_idx_p0;
        resp_value_p1 <= count_r;
        rr_ptr        <= (gnt_idx_p0 == LAST_ID) ? '0 : gnt_idx_p0 + 1'b1;
      end
      if (clear) begin
        count_r <= '0;
      end else if (xfer_p0) begin
        count_r <= count_nxt_p0;
      end
    end
  end

  // ---- stage p1: registered response ----
  assign resp_valid = resp_vld_p1;
  assign resp_id    = resp_id_p1;
  assign resp_value = resp_value_p1;
  assign count      = count_r;
`ifdef COUNTER_ARB_SAT_EN
  assign sat        = (state == SAT);
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed self-checking bench for counter_arbiter
// (NUM_REQ=4, WIDTH=4, STEP=1). Also builds with COUNTER_ARB_SAT_EN.
`timescale 1ns/1ps
module tb_counter_arbiter;
  import counter_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic       resp_valid;
  logic [1:0] resp_id;
  logic [3:0] resp_value;
  logic [3:0] count;
`ifdef COUNTER_ARB_SAT_EN
  logic       sat;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_arbiter #(.NUM_REQ(4), .WIDTH(4), .STEP(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_value (resp_value),
`ifdef COUNTER_ARB_SAT_EN
    .sat        (sat),
`endif
    .count      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resp_chk(input string tag, input int id, input int value);
    resp_t e;
    e.id    = 4'(id);
    e.value = 32'(value);
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_id"}, 32'(resp_id), 32'(e.id));
    chk({tag, "_value"}, 32'(resp_value), e.value);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; req_valid = 4'b0000;
    cyc(); cyc();

    // Reset state, with enable and requests applied: nothing may be granted.
    enable = 1'b1; req_valid = 4'b1111; #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_vld", 32'(resp_valid), 32'h0);
    chk("rst_id", 32'(resp_id), 32'h0);
    chk("rst_value", 32'(resp_value), 32'h0);
`ifdef COUNTER_ARB_SAT_EN
    chk("rst_sat", 32'(sat), 32'h0);
`endif
    cyc();
    chk("rst_hold_count", 32'(count), 32'h0);
    enable = 1'b0; req_valid = 4'b0000; reset = 1'b0;
    cyc();
    chk("idle_count", 32'(count), 32'h0);
    chk("idle_vld", 32'(resp_valid), 32'h0);

    // Single requester 0 for three cycles: tickets 0,1,2.
    enable = 1'b1; req_valid = 4'b0001; #1;
    chk("a_ready", 32'(req_ready), 32'h1);
    cyc(); resp_chk("a_g0", 0, 0); chk("a_count1", 32'(count), 32'd1);
    cyc(); resp_chk("a_g1", 0, 1); chk("a_count2", 32'(count), 32'd2);
    cyc(); resp_chk("a_g2", 0, 2); chk("a_count3", 32'(count), 32'd3);
    req_valid = 4'b0000;
    cyc();
    chk("a_idle_vld", 32'(resp_valid), 32'h0);
    chk("a_hold_count", 32'(count), 32'd3);

    // rr_ptr is 1; a lone request from 3 wins and moves the pointer to 0.
    req_valid = 4'b1000; #1;
    chk("b_align_ready", 32'(req_ready), 32'h8);
    cyc(); resp_chk("b_align", 3, 3);

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3 with tickets 4..11.
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b_rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      cyc();
      resp_chk("b_rr", i % 4, 4 + i);
    end
    req_valid = 4'b0000;
    cyc();
    chk("b_idle_vld", 32'(resp_valid), 32'h0);
    chk("b_count", 32'(count), 32'd12);

    // Bring count to 14 via requester 2 (pointer ends at 3).
    req_valid = 4'b0100;
    cyc(); resp_chk("c_pre12", 2, 12);
    cyc(); resp_chk("c_pre13", 2, 13);
    chk("c_count14", 32'(count), 32'd14);

    // Clear beats a simultaneous request.
    clear = 1'b1; req_valid = 4'b0010; #1;
    chk("c_clr_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("c_clr_count", 32'(count), 32'h0);
    chk("c_clr_vld", 32'(resp_valid), 32'h0);
    clear = 1'b0; #1;
    chk("c_post_ready", 32'(req_ready), 32'h2);
    cyc(); resp_chk("c_post", 1, 0);
    chk("c_post_count", 32'(count), 32'd1);

    // Ramp to 15 with requester 0.
    req_valid = 4'b0001;
    for (int k = 0; k < 14; k++) begin
      cyc();
      resp_chk("d_ramp", 0, 1 + k);
    end
    chk("d_count15", 32'(count), 32'd15);
`ifdef COUNTER_ARB_SAT_EN
    cyc(); resp_chk("s_last", 0, 15);
    chk("s_stick", 32'(count), 32'd15);
    chk("s_sat", 32'(sat), 32'h1);
    req_valid = 4'b1111; #1;
    chk("s_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("s_no_vld", 32'(resp_valid), 32'h0);
    chk("s_hold", 32'(count), 32'd15);
    clear = 1'b1;
    cyc();
    chk("s_clr_count", 32'(count), 32'h0);
    chk("s_clr_sat", 32'(sat), 32'h0);
    clear = 1'b0; req_valid = 4'b0001;
    cyc(); resp_chk("s_restart", 0, 0);
    chk("s_restart_count", 32'(count), 32'd1);
`else
    cyc(); resp_chk("d_wrap15", 0, 15);
    chk("d_wrap_count", 32'(count), 32'h0);
    cyc(); resp_chk("d_wrap0", 0, 0);
    chk("d_wrap_count1", 32'(count), 32'd1);
`endif

    // enable low blocks grants and holds count; clear still works.
    enable = 1'b0; req_valid = 4'b1111; #1;
    chk("e_dis_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("e_dis_vld", 32'(resp_valid), 32'h0);
    chk("e_dis_count", 32'(count), 32'd1);
    clear = 1'b1;
    cyc();
    chk("e_dis_clr", 32'(count), 32'h0);
    clear = 1'b0;

    // Nine grants to count 9 with a response pending, then asynchronous reset.
    enable = 1'b1; req_valid = 4'b0001;
    for (int k = 0; k < 9; k++) cyc();
    resp_chk("f_pre", 0, 8);
    chk("f_count9", 32'(count), 32'd9);
    reset = 1'b1; #2;
    chk("f_rst_vld", 32'(resp_valid), 32'h0);
    chk("f_rst_count", 32'(count), 32'h0);
    chk("f_rst_value", 32'(resp_value), 32'h0);
    chk("f_rst_id", 32'(resp_id), 32'h0);
    chk("f_rst_ready", 32'(req_ready), 32'h0);
    cyc();
    reset = 1'b0; req_valid = 4'b1111; #1;
    chk("f_ptr0_ready", 32'(req_ready), 32'h1);
    cyc(); resp_chk("f_restart", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shared-counter scheduler: arbitrates up to NUM_REQ requesters for a single WIDTH-bit up-counter and hands each winner a unique ticket, which is the counter value before its increment. It sits in front of the plain register-plus-incrementer counter datapath, replaces direct increment wiring when several agents need sequence numbers, and owns the counter's enable, clear and saturation policy.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 4, counter and ticket width
- STEP, 1, increment per grant (1..2^WIDTH-1)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 0 blocks all grants, counter holds
- clear  in  1  synchronous pulse; counter to 0 next edge
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant, combinational
- resp_valid  out  1  registered ticket strobe
- resp_id  out  clog2(NUM_REQ)  index of granted requester
- resp_value  out  WIDTH  ticket (pre-increment count)
- count  out  WIDTH  current counter register
- sat  out  1  saturated flag (present only with COUNTER_ARB_SAT_EN)

## Operation
- States: IDLE (enable=0), RUN, SAT (macro only). IDLE→RUN when enable=1; RUN→IDLE when enable=0; RUN→SAT when a grant would carry count past 2^WIDTH-1; SAT→RUN only on clear.
- In RUN, if any req_valid, exactly one req_ready bit is 1. Winner is the first valid index at or after rr_ptr, searching upward mod NUM_REQ.
- Handshake: transfer when req_valid[i] && req_ready[i]. Requesters hold valid until they receive ready; a dropped valid without ready is legal and has no effect.
- On transfer: count <= count + STEP (mod 2^WIDTH without macro); rr_ptr <= (i+1) mod NUM_REQ; resp_valid, resp_id=i, resp_value=old count registered.
- Responses have no backpressure. Consumers must accept them.
- clear has priority. In the clear cycle req_ready=0, count <= 0, rr_ptr is unchanged, and there is no response.
- enable=0: req_ready=0, count holds, and clear still acts.
- Arithmetic is WIDTH bits. STEP is truncated to WIDTH.

## Timing
- Reset values: count=0, rr_ptr=0, state=IDLE, resp_valid=0, resp_id=0, resp_value=0, sat=0, req_ready=0.
- req_ready is combinational from req_valid, state, rr_ptr, clear and enable. It has no input-to-register bypass.
- Latency: a grant in cycle n gives resp_valid in cycle n+1. resp_valid is a one-cycle pulse per grant.
- Throughput: one grant per cycle. Back-to-back grants are allowed.
- Wrap (no macro): at count=2^WIDTH-1 with STEP=1, the ticket is 2^WIDTH-1 and the next count is 0.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending resp_valid is lost.
- A requester that has continuously asserted valid is granted within NUM_REQ grants.

## Configuration
- COUNTER_ARB_SAT_EN defined:
  - The SAT state exists and the sat port exists.
  - A grant whose increment would overflow is still issued and gets ticket = count.
  - count then sticks at 2^WIDTH-1 and sat=1.
  - In SAT, req_ready=0 until clear.
- COUNTER_ARB_SAT_EN undefined: modular wrap, no SAT state, no sat port.

## Structure
- Package counter_arb_pkg:
  - state enum {IDLE, RUN, SAT}
  - ID_W = clog2(NUM_REQ) helper
  - response struct {id, value}
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr; outputs one-hot gnt and encoded index. It is purely combinational.
- The top holds the state register, counter, rr_ptr and response registers.

## Test plan
- Reset, then enable=1, req_valid=0001 for 3 cycles → resp_value 0,1,2 and resp_id 0 on cycles 2–4, count=3.
- req_valid=1111 held 8 cycles → grant order 0,1,2,3,0,1,2,3 and tickets 0..7 in order, with no gaps or duplicates.
- count=14, clear and req_valid=0010 in the same cycle → req_ready=0, count=0 next edge, no resp_valid; the next cycle grants requester 1 with ticket 0.
- WIDTH=4, STEP=1, 17 grants (no macro) → the 16th ticket is 15 and the 17th ticket is 0.
- With COUNTER_ARB_SAT_EN and count=15 after one grant → sat=1, req_ready stays 0 under req_valid=1111 until clear, then tickets restart at 0.
- Assert reset asynchronously while resp_valid=1 and count=9 → outputs go to 0 before the next clk edge, and state is IDLE.
